// File: rtl/tagged_rr_arbiter_if.sv
// Stream interfaces for the tagged arbiter: tagged producer lanes (tagged_i)
// and the plain registered output stream (data_i).
interface tagged_i #(
  parameter type tuple_t   = logic [7:0],
  parameter int  TAG_WIDTH = 2
);
  tuple_t               data;
  logic                 keep;
  logic                 last;
  logic                 valid;
  logic [TAG_WIDTH-1:0] tag;
  logic                 ready;

  modport m (output data, keep, last, valid, tag, input ready);
  modport s (input data, keep, last, valid, tag, output ready);
endinterface

interface data_i #(
  parameter type tuple_t = logic [7:0]
);
  tuple_t data;
  logic   keep;
  logic   last;
  logic   valid;
  logic   ready;

  modport m (output data, keep, last, valid, input ready);
  modport s (input data, keep, last, valid, output ready);
endinterface

// File: rtl/tagged_rr_arbiter.sv
// Round-robin arbiter draining beats tagged with ID from shared tagged lanes into one
// registered stream; per-lane last flags are merged into a single last per stream.
module tagged_rr_arbiter #(
  parameter type                  tuple_t     = logic [7:0],
  parameter int                   TAG_WIDTH   = 2,
  parameter logic [TAG_WIDTH-1:0] ID          = '0,
  parameter int                   NUM_INPUTS  = 4,
  parameter bit                   FILTER_KEEP = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  tagged_i.s          in [NUM_INPUTS],
  data_i.m            out,
  output logic [31:0] streams_done
);
  localparam int PTR_W = $clog2(NUM_INPUTS);
  localparam int IDX_W = PTR_W + 1;

  typedef enum logic [0:0] {RUN = 1'b0, FLUSH = 1'b1} state_t;

  state_t                state_r;
  logic [PTR_W-1:0]      ptr_r;
  logic [NUM_INPUTS-1:0] last_seen_r;
  tuple_t                data_r;
  logic                  keep_r;
  logic                  last_r;
  logic                  valid_r;
  logic [31:0]           streams_done_r;

  tuple_t                data_s  [NUM_INPUTS];
  logic [TAG_WIDTH-1:0]  tag_s   [NUM_INPUTS];
  logic                  valid_s [NUM_INPUTS];
  logic                  keep_s  [NUM_INPUTS];
  logic                  last_s  [NUM_INPUTS];
  logic [NUM_INPUTS-1:0] ready_s;
  logic [NUM_INPUTS-1:0] match_s;
  logic [NUM_INPUTS-1:0] elig_s;
  logic [NUM_INPUTS-1:0] drop_s;
  logic [NUM_INPUTS-1:0] set_s;
  logic [NUM_INPUTS-1:0] nls_s;
  logic                  free_s;
  logic                  found_s;
  logic                  gnt_s;
  logic [PTR_W-1:0]      gnt_idx_s;
  logic [IDX_W-1:0]      sum_s;
  logic [IDX_W-1:0]      idx_s;

  for (genvar g = 0; g < NUM_INPUTS; g++) begin : g_lane
    assign data_s[g]   = in[g].data;
    assign tag_s[g]    = in[g].tag;
    assign valid_s[g]  = in[g].valid;
    assign keep_s[g]   = in[g].keep;
    assign last_s[g]   = in[g].last;
    assign in[g].ready = ready_s[g];
  end

  assign out.data     = data_r;
  assign out.keep     = keep_r;
  assign out.last     = last_r;
  assign out.valid    = valid_r;
  assign streams_done = streams_done_r;

  // Per-lane classification: tag match, eligibility for grant, and filter drop.
  always_comb begin
    free_s  = !valid_r || out.ready;
    match_s = '0;
    elig_s  = '0;
    drop_s  = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      match_s[i] = (tag_s[i] == ID);
      elig_s[i]  = (state_r == RUN) && valid_s[i] && match_s[i] && !last_seen_r[i] &&
                   (!FILTER_KEEP || keep_s[i]);
      // Lanes already done with this stream keep their next-stream beats parked, drops included.
      drop_s[i]  = (state_r == RUN) && valid_s[i] && match_s[i] && !last_seen_r[i] &&
                   FILTER_KEEP && !keep_s[i];
    end
  end

  // Cyclic scan for the first eligible lane starting at ptr_r.
  always_comb begin
    found_s   = 1'b0;
    gnt_idx_s = '0;
    sum_s     = '0;
    idx_s     = '0;
    for (int k = 0; k < NUM_INPUTS; k++) begin
      sum_s = {1'b0, ptr_r} + IDX_W'(k);
      idx_s = (sum_s >= IDX_W'(NUM_INPUTS)) ? (sum_s - IDX_W'(NUM_INPUTS)) : sum_s;
      if (!found_s && elig_s[idx_s[PTR_W-1:0]]) begin
        found_s   = 1'b1;
        gnt_idx_s = idx_s[PTR_W-1:0];
      end else begin
        gnt_idx_s = gnt_idx_s;
      end
    end
    gnt_s = found_s && free_s;
  end

  // Lane readies and the next value of the per-lane last flags.
  always_comb begin
    ready_s = '0;
    set_s   = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      // Non-matching lanes follow free so sibling instances can AND their readies.
      if (rst) begin
        ready_s[i] = 1'b0;
      end else if (gnt_s && (gnt_idx_s == PTR_W'(i))) begin
        ready_s[i] = 1'b1;
      end else if (!match_s[i]) begin
        ready_s[i] = free_s;
      end else if (drop_s[i]) begin
        ready_s[i] = free_s;
      end else begin
        ready_s[i] = 1'b0;
      end
      set_s[i] = (gnt_s && (gnt_idx_s == PTR_W'(i)) && last_s[i]) ||
                 (free_s && valid_s[i] && !match_s[i] && last_s[i]) ||
                 (free_s && drop_s[i] && last_s[i]);
    end
    nls_s = last_seen_r | set_s;
  end

  // Output register, round-robin pointer, last merge and RUN/FLUSH control.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= RUN;
      ptr_r       <= '0;
      last_seen_r <= '0;
      data_r      <= '0;
      keep_r      <= 1'b0;
      last_r      <= 1'b0;
      valid_r     <= 1'b0;
    end else begin
      case (state_r)
        RUN: begin
          if (free_s && gnt_s) begin
            data_r      <= data_s[gnt_idx_s];
            keep_r      <= keep_s[gnt_idx_s];
            last_r      <= &nls_s;
            valid_r     <= 1'b1;
            last_seen_r <= (&nls_s) ? '0 : nls_s;
            ptr_r       <= (gnt_idx_s == PTR_W'(NUM_INPUTS - 1)) ? '0 : (gnt_idx_s + 1'b1);
          end else if (free_s) begin
            // Every lane finished without a beat to carry last: emit a dummy next cycle.
            valid_r     <= 1'b0;
            last_seen_r <= nls_s;
            state_r     <= (&nls_s) ? FLUSH : RUN;
          end else begin
            valid_r <= valid_r;
          end
        end
        FLUSH: begin
          if (free_s) begin
            keep_r      <= 1'b0;
            last_r      <= 1'b1;
            valid_r     <= 1'b1;
            last_seen_r <= '0;
            state_r     <= RUN;
          end else begin
            state_r <= FLUSH;
          end
        end
        default: begin
          state_r <= RUN;
        end
      endcase
    end
  end

  // Completed-stream counter, wraps naturally at 32 bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      streams_done_r <= 32'd0;
    end else if (valid_r && out.ready && last_r) begin
      streams_done_r <= streams_done_r + 32'd1;
    end else begin
      streams_done_r <= streams_done_r;
    end
  end
endmodule

// File: tb/tb_tagged_rr_arbiter.sv
// Directed bench for tagged_rr_arbiter: lane queues feed the DUT, accepted output
// beats are collected and compared against hand-computed sequences.
module tb_tagged_rr_arbiter;
  localparam logic [1:0] ID_T  = 2'd1;
  localparam logic [1:0] FOR_T = 2'd2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ordy;
  logic [7:0]  ldata  [4];
  logic [1:0]  ltag   [4];
  logic        lkeep  [4];
  logic        llast  [4];
  logic        lvalid [4];
  logic        lready [4];
  logic [7:0]  o_data;
  logic        o_keep;
  logic        o_last;
  logic        o_valid;
  logic [31:0] streams_done;

  logic [11:0] lq [4][$];
  logic [9:0]  obs [$];
  int          checks;
  int          errors;

  always #5 clk = ~clk;

  tagged_i #(.tuple_t(logic [7:0]), .TAG_WIDTH(2)) lanes [4] ();
  data_i   #(.tuple_t(logic [7:0]))                out_if ();

  for (genvar g = 0; g < 4; g++) begin : g_conn
    assign lanes[g].data  = ldata[g];
    assign lanes[g].tag   = ltag[g];
    assign lanes[g].keep  = lkeep[g];
    assign lanes[g].last  = llast[g];
    assign lanes[g].valid = lvalid[g];
    assign lready[g]      = lanes[g].ready;
  end

  assign o_data       = out_if.data;
  assign o_keep       = out_if.keep;
  assign o_last       = out_if.last;
  assign o_valid      = out_if.valid;
  assign out_if.ready = ordy;

  tagged_rr_arbiter #(
    .tuple_t(logic [7:0]), .TAG_WIDTH(2), .ID(ID_T), .NUM_INPUTS(4), .FILTER_KEEP(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .in(lanes), .out(out_if), .streams_done(streams_done)
  );

  function automatic logic [11:0] mk(input logic [7:0] d, input logic [1:0] t,
                                     input logic k, input logic l);
    return {d, t, k, l};
  endfunction

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      if (lq[i].size() != 0) begin
        {ldata[i], ltag[i], lkeep[i], llast[i]} = lq[i][0];
        lvalid[i] = 1'b1;
      end else begin
        ldata[i] = 8'h00; ltag[i] = 2'd0; lkeep[i] = 1'b0; llast[i] = 1'b0; lvalid[i] = 1'b0;
      end
    end
  endtask

  // Handshakes are sampled on the falling edge and take effect on the next rising edge.
  task automatic cyc();
    logic [3:0]  f;
    logic [11:0] tmp;
    @(negedge clk);
    for (int i = 0; i < 4; i++) f[i] = lvalid[i] && lready[i];
    if (o_valid && ordy) obs.push_back({o_data, o_keep, o_last});
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) if (f[i]) tmp = lq[i].pop_front();
    drive();
  endtask

  task automatic run(input int max_cyc);
    int n;
    n = 0;
    while ((lq[0].size() + lq[1].size() + lq[2].size() + lq[3].size()) != 0 && n < max_cyc) begin
      cyc();
      n++;
    end
    checks++;
    if (n >= max_cyc) begin
      errors++;
      $display("FAIL run_timeout got %0d cycles want fewer than %0d", n, max_cyc);
    end
    repeat (3) cyc();
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    lq[0].push_back(mk(8'h11, ID_T, 1'b1, 1'b0));
    lq[1].push_back(mk(8'h22, FOR_T, 1'b1, 1'b1));
    drive();
    #2;
    checks += 4;
    if (o_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", o_valid); end
    if (o_last !== 1'b0) begin errors++; $display("FAIL rst_last got %b want 0", o_last); end
    if (o_keep !== 1'b0) begin errors++; $display("FAIL rst_keep got %b want 0", o_keep); end
    if (streams_done !== 32'd0) begin errors++; $display("FAIL rst_streams got %0d want 0", streams_done); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (lready[i] !== 1'b0) begin errors++; $display("FAIL rst_ready%0d got %b want 0", i, lready[i]); end
    end
    for (int i = 0; i < 4; i++) lq[i].delete();
    drive();
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_fairness();
    logic [9:0] want;
    int cnt [4];
    obs.delete();
    for (int n = 0; n < 25; n++)
      for (int i = 0; i < 4; i++) lq[i].push_back(mk(8'(i * 64 + n), ID_T, 1'b1, 1'b0));
    drive();
    run(300);
    checks++;
    if (obs.size() != 100) begin errors++; $display("FAIL fair_count got %0d want 100", obs.size()); end
    for (int k = 0; k < 100; k++) begin
      want = {8'((k % 4) * 64 + k / 4), 1'b1, 1'b0};
      checks++;
      if (k >= obs.size() || obs[k] !== want) begin
        errors++;
        $display("FAIL fair_beat%0d got %h want %h", k, (k < obs.size()) ? obs[k] : 10'h0, want);
      end
    end
    for (int i = 0; i < 4; i++) cnt[i] = 0;
    for (int k = 0; k < obs.size(); k++) cnt[obs[k][9:8]]++;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (cnt[i] != 25) begin errors++; $display("FAIL fair_lane%0d got %0d want 25", i, cnt[i]); end
    end
  endtask

  task automatic test_backpressure();
    logic [9:0] ex [4];
    obs.delete();
    ordy = 1'b0;
    lq[0].push_back(mk(8'h00, ID_T, 1'b1, 1'b0));
    lq[0].push_back(mk(8'h01, ID_T, 1'b1, 1'b0));
    lq[1].push_back(mk(8'h40, ID_T, 1'b1, 1'b0));
    lq[1].push_back(mk(8'h41, ID_T, 1'b1, 1'b0));
    drive();
    cyc();
    for (int c = 0; c < 5; c++) begin
      cyc();
      checks += 4;
      if (o_valid !== 1'b1) begin errors++; $display("FAIL bp_valid c%0d got %b want 1", c, o_valid); end
      if (o_data !== 8'h00) begin errors++; $display("FAIL bp_data c%0d got %h want 00", c, o_data); end
      if (lready[0] !== 1'b0) begin errors++; $display("FAIL bp_ready0 c%0d got %b want 0", c, lready[0]); end
      if (lready[1] !== 1'b0) begin errors++; $display("FAIL bp_ready1 c%0d got %b want 0", c, lready[1]); end
    end
    ordy = 1'b1;
    run(50);
    ex = '{{8'h00, 1'b1, 1'b0}, {8'h40, 1'b1, 1'b0}, {8'h01, 1'b1, 1'b0}, {8'h41, 1'b1, 1'b0}};
    checks++;
    if (obs.size() != 4) begin errors++; $display("FAIL bp_count got %0d want 4", obs.size()); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (k >= obs.size() || obs[k] !== ex[k]) begin
        errors++;
        $display("FAIL bp_beat%0d got %h want %h", k, (k < obs.size()) ? obs[k] : 10'h0, ex[k]);
      end
    end
  endtask

  task automatic test_last_merge();
    logic [9:0] ex [15];
    obs.delete();
    for (int i = 0; i < 4; i++) begin
      if (i == 1) repeat (4) lq[1].push_back(mk(8'hEE, FOR_T, 1'b1, 1'b0));
      for (int n = 0; n < 3; n++) lq[i].push_back(mk(8'(i * 64 + n), ID_T, 1'b1, (n == 2)));
      if (i != 1) lq[i].push_back(mk(8'(i * 64 + 3), ID_T, 1'b1, 1'b0));
    end
    drive();
    run(100);
    ex = '{{8'h80, 1'b1, 1'b0}, {8'hC0, 1'b1, 1'b0}, {8'h00, 1'b1, 1'b0}, {8'h81, 1'b1, 1'b0},
           {8'hC1, 1'b1, 1'b0}, {8'h01, 1'b1, 1'b0}, {8'h40, 1'b1, 1'b0}, {8'h82, 1'b1, 1'b0},
           {8'hC2, 1'b1, 1'b0}, {8'h02, 1'b1, 1'b0}, {8'h41, 1'b1, 1'b0}, {8'h42, 1'b1, 1'b1},
           {8'h83, 1'b1, 1'b0}, {8'hC3, 1'b1, 1'b0}, {8'h03, 1'b1, 1'b0}};
    checks++;
    if (obs.size() != 15) begin errors++; $display("FAIL merge_count got %0d want 15", obs.size()); end
    for (int k = 0; k < 15; k++) begin
      checks++;
      if (k >= obs.size() || obs[k] !== ex[k]) begin
        errors++;
        $display("FAIL merge_beat%0d got %h want %h", k, (k < obs.size()) ? obs[k] : 10'h0, ex[k]);
      end
    end
    checks++;
    if (streams_done !== 32'd1) begin errors++; $display("FAIL merge_streams got %0d want 1", streams_done); end
  endtask

  task automatic test_flush();
    logic [9:0] ex [4];
    obs.delete();
    lq[0].push_back(mk(8'h10, ID_T, 1'b1, 1'b0));
    lq[0].push_back(mk(8'h11, ID_T, 1'b1, 1'b1));
    lq[1].push_back(mk(8'h50, ID_T, 1'b1, 1'b1));
    repeat (3) lq[2].push_back(mk(8'hAA, FOR_T, 1'b1, 1'b0));
    lq[2].push_back(mk(8'hAB, FOR_T, 1'b1, 1'b1));
    repeat (4) lq[3].push_back(mk(8'hCC, FOR_T, 1'b1, 1'b0));
    lq[3].push_back(mk(8'hCD, FOR_T, 1'b1, 1'b1));
    drive();
    run(50);
    ex = '{{8'h50, 1'b1, 1'b0}, {8'h10, 1'b1, 1'b0}, {8'h11, 1'b1, 1'b0}, {8'h11, 1'b0, 1'b1}};
    checks++;
    if (obs.size() != 4) begin errors++; $display("FAIL flush_count got %0d want 4", obs.size()); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (k >= obs.size() || obs[k] !== ex[k]) begin
        errors++;
        $display("FAIL flush_beat%0d got %h want %h", k, (k < obs.size()) ? obs[k] : 10'h0, ex[k]);
      end
    end
    checks++;
    if (streams_done !== 32'd2) begin errors++; $display("FAIL flush_streams got %0d want 2", streams_done); end
  endtask

  task automatic test_keep_filter();
    logic [9:0] ex [4];
    obs.delete();
    lq[0].push_back(mk(8'h20, ID_T, 1'b1, 1'b0));
    lq[0].push_back(mk(8'h21, ID_T, 1'b1, 1'b1));
    lq[1].push_back(mk(8'h60, ID_T, 1'b0, 1'b0));
    lq[1].push_back(mk(8'h61, ID_T, 1'b0, 1'b1));
    lq[2].push_back(mk(8'hA0, ID_T, 1'b1, 1'b1));
    lq[3].push_back(mk(8'hE0, ID_T, 1'b1, 1'b1));
    drive();
    run(50);
    ex = '{{8'hA0, 1'b1, 1'b0}, {8'hE0, 1'b1, 1'b0}, {8'h20, 1'b1, 1'b0}, {8'h21, 1'b1, 1'b1}};
    checks++;
    if (obs.size() != 4) begin errors++; $display("FAIL keep_count got %0d want 4", obs.size()); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (k >= obs.size() || obs[k] !== ex[k]) begin
        errors++;
        $display("FAIL keep_beat%0d got %h want %h", k, (k < obs.size()) ? obs[k] : 10'h0, ex[k]);
      end
    end
    checks++;
    if (streams_done !== 32'd3) begin errors++; $display("FAIL keep_streams got %0d want 3", streams_done); end
  endtask

  task automatic test_async_reset();
    logic [9:0] ex [4];
    obs.delete();
    lq[2].push_back(mk(8'h90, ID_T, 1'b1, 1'b1));
    lq[3].push_back(mk(8'hD0, ID_T, 1'b1, 1'b0));
    drive();
    cyc();
    #2 rst = 1'b1;
    #1;
    checks += 3;
    if (o_valid !== 1'b0) begin errors++; $display("FAIL arst_valid got %b want 0", o_valid); end
    if (lready[3] !== 1'b0) begin errors++; $display("FAIL arst_ready3 got %b want 0", lready[3]); end
    if (streams_done !== 32'd0) begin errors++; $display("FAIL arst_streams got %0d want 0", streams_done); end
    for (int i = 0; i < 4; i++) lq[i].delete();
    drive();
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
    obs.delete();
    lq[0].push_back(mk(8'h30, ID_T, 1'b1, 1'b1));
    lq[1].push_back(mk(8'h70, ID_T, 1'b1, 1'b1));
    lq[2].push_back(mk(8'hB0, ID_T, 1'b1, 1'b0));
    lq[3].push_back(mk(8'hF0, ID_T, 1'b1, 1'b1));
    drive();
    run(50);
    ex = '{{8'h30, 1'b1, 1'b0}, {8'h70, 1'b1, 1'b0}, {8'hB0, 1'b1, 1'b0}, {8'hF0, 1'b1, 1'b0}};
    checks++;
    if (obs.size() != 4) begin errors++; $display("FAIL arst_count got %0d want 4", obs.size()); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (k >= obs.size() || obs[k] !== ex[k]) begin
        errors++;
        $display("FAIL arst_beat%0d got %h want %h", k, (k < obs.size()) ? obs[k] : 10'h0, ex[k]);
      end
    end
    checks++;
    if (streams_done !== 32'd0) begin errors++; $display("FAIL arst_streams_after got %0d want 0", streams_done); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    ordy   = 1'b1;
    drive();
    test_reset();
    test_fairness();
    test_backpressure();
    test_last_merge();
    test_flush();
    test_keep_filter();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/tagged_rr_arbiter.md
# tagged_rr_arbiter

Round-robin arbiter that drains the beats tagged with its `ID` from `NUM_INPUTS` tagged producer lanes into one registered output stream. It is the fairness-aware replacement for the fixed-priority tagged mux stage in the crossbar: one instance per crossbar output, all instances sharing the same input lanes. Stream boundaries are merged: the block emits exactly one `last` per stream, after every lane has delivered its `last`.

## Interface
Parameters:
- `tuple_t`, none: beat payload type.
- `ID`, none: tag value this instance claims.
- `NUM_INPUTS`, 4: number of input lanes, at least 2.
- `TAG_WIDTH`, none: width of `in[i].tag`.
- `FILTER_KEEP`, 1: when 1, matching beats with `keep=0` are consumed and dropped; when 0, they are arbitrated like any other beat.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst`, input, 1: reset, asynchronous and active-high.
- `in[NUM_INPUTS]`, `tagged_i.s`, payload `tuple_t` and tag `TAG_WIDTH`: input lanes with `data`, `keep`, `last`, `valid`, `tag` and `ready`.
- `out`, `data_i.m`, payload `tuple_t`: registered output with `data`, `keep`, `last`, `valid` and `ready`.
- `streams_done`, output, 32: count of `last` beats transferred on `out`; wraps modulo 2^32.

## Operation
- Definitions:
  - `match[i]` = `in[i].tag == ID`.
  - `free` = `!out.valid || out.ready`.
  - `elig[i]` = `in[i].valid && match[i] && (!FILTER_KEEP || in[i].keep) && !last_seen[i] && state==RUN`.
- State: round-robin pointer `ptr` (clog2(NUM_INPUTS) bits), `last_seen[NUM_INPUTS]`, output register, FSM {RUN, FLUSH}.
- Grant rule: when `free` is high in RUN, `grant` is the first `i` with `elig[i]` set, scanning cyclically from `ptr`. After a grant, `ptr <= (grant+1) mod NUM_INPUTS`. With no grant, `ptr` holds. At most one grant per cycle.
- Ready rules:
  - `in[grant].ready = 1`.
  - Any other matching lane has `ready = 0`, except a lane whose current beat is filter-dropped (matching tag, `keep=0`, `FILTER_KEEP=1`). Such a lane has `ready = free` and its beat is discarded.
  - A non-matching lane has `ready = free`. This lets sibling instances combine their readies by AND externally.
- Load on grant: `out.data`, `out.keep` <= granted beat; `out.valid <= 1`. If the granted beat has `last`, set `last_seen[grant]`.
- Foreign last: a non-matching lane with `valid && last` while `free` sets `last_seen[i]`. A filter-dropped beat with `last` also sets `last_seen[i]`.
- Merge: let `nls` be the next value of `last_seen`.
  - If `&nls` and a beat is loaded this cycle: that beat gets `out.last=1`, `last_seen <= 0`, state stays RUN.
  - If `&nls` and no beat is loaded: `last_seen <= nls`, state <= FLUSH.
  - Otherwise loaded beats have `out.last=0`.
- FLUSH: all matching lanes have `ready=0`. When `free`: load a dummy beat (`keep=0`, `last=1`, `data` held), `last_seen <= 0`, state <= RUN.
- When `out.valid && !out.ready`, the output register holds and no grants are issued.
- `streams_done` increments on every `out.valid && out.ready && out.last`.

## Timing
- Reset (asynchronous assert, released synchronously to `clk`):
  - `out.valid=0`, `out.last=0`, `out.keep=0`, `streams_done=0`, `ptr=0`, `last_seen=0`, state RUN.
  - All `in[i].ready=0` while `rst` is high.
  - `out.data` is undefined after reset.
- Latency: 1 cycle from input transfer to `out.valid`.
- Throughput: 1 beat per cycle when `out.ready` stays high.
- `in[i].ready` is combinational from `out.ready`, the lane inputs and registered state. There is no combinational path from `in[i].valid` of lane i to `in[i].ready` of lane i beyond grant selection.
- Reset mid-stream discards the output register and all `last_seen` flags.
- `NUM_INPUTS` that is not a power of 2: `ptr` wraps from `NUM_INPUTS-1` to 0.

## Test plan
- Fairness: 4 lanes, all continuously valid with `tag=ID`, `out.ready=1`. Required: output lane order 0,1,2,3,0,1,… and each lane gets exactly 25 of 100 beats.
- Backpressure: hold `out.ready=0` for 5 cycles with beat A registered. Required: A held stable, every matching `ready=0`, no beat lost or duplicated after release.
- Last merge: lanes 0–3 each send 3 beats, the last one marked `last`. Required: 12 beats out; only the 12th has `last=1`; `streams_done=1`; next-stream beats are stalled until the merge.
- Foreign last / FLUSH: lanes 0,1 end with matching beats; lanes 2,3 send only non-matching `last` beats after that. Required: a dummy beat with `keep=0`, `last=1` one cycle after `&last_seen` (given `out.ready=1`); state returns to RUN.
- Keep filter: with `FILTER_KEEP=1`, lane 1 sends `keep=0` beats. Required: they are consumed with no output, `ptr` is unaffected, and a `keep=0, last=1` beat still counts toward `last_seen`.
- Async reset: assert `rst` mid-stream between clock edges. Required: `out.valid` drops immediately; after release, `ptr=0` and `streams_done=0`.
